uram_row_arbiter: RTL and testbench
===================================

# uram_row_arbiter

Parametrised arbiter and row barrier between NUM_CORES RISC-V core tops and one shared URAM write port. It replaces the single-core "grant on request" handshake with round-robin arbitration of the core_req/core_grant/core_locked protocol. It muxes the owning core's URAM port onto a registered output, and enforces a row barrier: every core must finish one locked session before the external drain runs. i_uram_emptied is then broadcast back to all cores.

## Interface
- NUM_CORES, 4: number of cores arbitrated (2..16).
- ADDR_W, 12: URAM address width.
- DATA_W, 32: URAM data width.
- GRANT_TIMEOUT, 256: cycles a granted core may take to raise locked; 0 disables the timeout.
- BARRIER_EN, 1: 1 means a core that has completed its session is masked until the drain; 0 gives free-running round-robin with no barrier.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_core_req  in  NUM_CORES  per-core ownership request.
- o_core_grant  out  NUM_CORES  one-hot grant (registered).
- i_core_locked  in  NUM_CORES  per-core "owns URAM" indication.
- o_uram_emptied  out  1  one-cycle pulse broadcast to all cores after a drain.
- i_URAM_en, i_URAM_wr_en  in  NUM_CORES each  per-core URAM strobes.
- i_URAM_addr  in  NUM_CORES*ADDR_W  per-core address, core k at bits [k*ADDR_W +: ADDR_W].
- i_URAM_wr_data  in  NUM_CORES*DATA_W  per-core write data, same packing.
- o_URAM_en, o_URAM_wr_en  out  1 each  muxed strobes (registered).
- o_URAM_addr  out  ADDR_W  muxed address (registered).
- o_URAM_wr_data  out  DATA_W  muxed write data (registered).
- o_row_full  out  1  barrier reached; level held until the drain completes.
- i_drain_done  in  1  pulse from the downstream consumer indicating the row has been read out.
- o_owner  out  clog2(NUM_CORES)  index of the current or last owner.
- o_wr_count  out  16  URAM writes accepted since the last drain (saturating).
- o_timeout_err  out  1  sticky flag; cleared only by reset.

## Operation
- Reset (reset=0) drives every output to 0. The round-robin pointer resets to NUM_CORES-1, so core 0 wins first. The done mask, timer and state are all cleared.
- States: IDLE, GRANT, OWNED, BARRIER, EMPTY.
- IDLE: the eligible set is i_core_req & ~done (or just i_core_req if BARRIER_EN=0).
  - If the set is non-empty, pick the first eligible core searching upward from pointer+1 with wrap-around.
  - Register o_core_grant[owner]=1 and o_owner, load the timer, and go to GRANT.
- GRANT: wait for i_core_locked[owner]=1, then go to OWNED.
  - If the timer expires first (GRANT_TIMEOUT cycles, when non-zero): drop the grant, set o_timeout_err, do not set done, advance the pointer, go to IDLE.
  - Deasserting req in GRANT does not cancel the grant; only locked or the timeout ends it.
- OWNED: only the owner's URAM inputs are forwarded; other cores' strobes are ignored. Each forwarded i_URAM_en & i_URAM_wr_en increments o_wr_count, saturating at 16'hFFFF.
  - Falling edge of i_core_locked[owner] ends the session:
    - clear the grant;
    - set done[owner];
    - set pointer=owner;
    - go to BARRIER if BARRIER_EN=1 and done becomes all-ones, else go to IDLE.
- BARRIER: o_row_full=1 and no grants are issued. On i_drain_done=1, go to EMPTY.
- EMPTY (one cycle): o_uram_emptied=1, done cleared, o_wr_count cleared, o_row_full cleared, then IDLE.
- Locked edges from non-owners are ignored.
- i_drain_done outside BARRIER is ignored.

## Timing
- Grant latency: o_core_grant rises exactly 1 cycle after req is sampled in IDLE.
- After a locked falling edge, grant falls 1 cycle later. The next grant to a different core comes no earlier than 2 cycles after that edge (IDLE, then GRANT), giving a one-cycle bubble.
- URAM path latency is 1 cycle: the owner's inputs at cycle t appear on the o_URAM_* outputs at t+1.
- The cycle in which locked falls still forwards the owner's strobes. From the next cycle the o_URAM_en/wr_en outputs are 0.
- o_URAM_addr and o_URAM_wr_data hold their last value whenever en=0.
- o_uram_emptied rises exactly 1 cycle after i_drain_done is sampled in BARRIER, and is high for exactly 1 cycle.
- Timeout: the grant is dropped on the cycle the timer reaches 0, which is GRANT_TIMEOUT cycles after the grant rose.
- Asynchronous reset mid-OWNED: the outputs clear immediately and the write in flight is dropped.

## Test plan
- NUM_CORES=4, all reqs high at once, each core locks 3 cycles and writes 16 words -> grants go 0,1,2,3. o_row_full=1 after core 3 unlocks, o_wr_count=64.
- In BARRIER, pulse i_drain_done -> o_uram_emptied high for 1 cycle exactly 1 cycle later. o_wr_count=0, and the next grant goes to core 0.
- Core 2 holds req but never locks, GRANT_TIMEOUT=8 -> grant drops after 8 cycles and o_timeout_err=1. Core 3 is granted next; the barrier does not complete until core 2 finishes.
- Non-owner core 1 asserts en/wr_en with addr=0x055 while core 0 owns -> o_URAM_addr reflects only core 0's addresses, and o_wr_count counts only core 0's writes.
- BARRIER_EN=0, core 0 requests repeatedly -> it is re-granted each session and o_row_full is never asserted.
- reset=0 asynchronously during OWNED -> all outputs are 0 in the same cycle. After release, core 0 wins the first grant.

Source files
------------

// File: rtl/uram_row_arbiter.sv
// Round-robin arbiter and row barrier sharing one URAM write port among NUM_CORES cores.
// The owner's URAM strobes are forwarded through one register stage; all outputs are registered.
module uram_row_arbiter #(
    parameter int unsigned NUM_CORES     = 4,
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned GRANT_TIMEOUT = 256,
    parameter int unsigned BARRIER_EN    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          i_core_req,
    output logic [NUM_CORES-1:0]          o_core_grant,
    input  logic [NUM_CORES-1:0]          i_core_locked,
    output logic                          o_uram_emptied,
    input  logic [NUM_CORES-1:0]          i_URAM_en,
    input  logic [NUM_CORES-1:0]          i_URAM_wr_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   i_URAM_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   i_URAM_wr_data,
    output logic                          o_URAM_en,
    output logic                          o_URAM_wr_en,
    output logic [ADDR_W-1:0]             o_URAM_addr,
    output logic [DATA_W-1:0]             o_URAM_wr_data,
    output logic                          o_row_full,
    input  logic                          i_drain_done,
    output logic [$clog2(NUM_CORES)-1:0]  o_owner,
    output logic [15:0]                   o_wr_count,
    output logic                          o_timeout_err
);
    localparam int unsigned OW = $clog2(NUM_CORES);
    localparam int unsigned TW = $clog2(GRANT_TIMEOUT + 2);

    typedef enum logic [2:0] {IDLE, GRANT, OWNED, BARRIER, EMPTY} state_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          ptr_q, ptr_d;
    logic [NUM_CORES-1:0]   done_q, done_d;
    logic [TW-1:0]          timer_q, timer_d;

    logic [NUM_CORES-1:0]   grant_d;
    logic [OW-1:0]          owner_d;
    logic                   emptied_d;
    logic                   uram_en_d, uram_wr_en_d;
    logic [ADDR_W-1:0]      addr_d;
    logic [DATA_W-1:0]      data_d;
    logic                   row_full_d;
    logic [15:0]            wr_count_d;
    logic                   timeout_d;

    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   done_set;
    logic [OW-1:0]          pick, cand;
    logic                   found;

    logic [ADDR_W-1:0]      addr_arr [NUM_CORES];
    logic [DATA_W-1:0]      data_arr [NUM_CORES];

    // Unpack the per-core address/data buses so the owner can be selected by index.
    for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
        assign addr_arr[k] = i_URAM_addr[k*ADDR_W +: ADDR_W];
        assign data_arr[k] = i_URAM_wr_data[k*DATA_W +: DATA_W];
    end

    assign done_set = done_q | (NUM_CORES'(1) << o_owner);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        done_d       = done_q;
        timer_d      = timer_q;
        grant_d      = o_core_grant;
        owner_d      = o_owner;
        emptied_d    = 1'b0;
        uram_en_d    = 1'b0;
        uram_wr_en_d = 1'b0;
        addr_d       = o_URAM_addr;
        data_d       = o_URAM_wr_data;
        row_full_d   = o_row_full;
        wr_count_d   = o_wr_count;
        timeout_d    = o_timeout_err;

        eligible = (BARRIER_EN != 0) ? (i_core_req & ~done_q) : i_core_req;

        // First eligible core searching upward from ptr+1 with wrap-around.
        pick  = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int i = 1; i <= int'(NUM_CORES); i++) begin
            cand = OW'((int'(ptr_q) + i) % int'(NUM_CORES));
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = NUM_CORES'(1) << pick;
                    owner_d = pick;
                    timer_d = TW'(GRANT_TIMEOUT);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (i_core_locked[o_owner]) begin
                    state_d = OWNED;
                end else if (timer_q == TW'(1)) begin
                    // Grant expired without a lock: release it and move the pointer past this core.
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    ptr_d     = o_owner;
                    timer_d   = '0;
                    state_d   = IDLE;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end
            end
            OWNED: begin
                uram_en_d    = i_URAM_en[o_owner];
                uram_wr_en_d = i_URAM_wr_en[o_owner];
                if (i_URAM_en[o_owner]) begin
                    addr_d = addr_arr[o_owner];
                    data_d = data_arr[o_owner];
                end
                if (i_URAM_en[o_owner] && i_URAM_wr_en[o_owner] && (o_wr_count != 16'hFFFF)) begin
                    wr_count_d = o_wr_count + 16'd1;
                end
                // Locked only stays high while in OWNED, so a low level is the falling edge.
                if (!i_core_locked[o_owner]) begin
                    grant_d = '0;
                    done_d  = done_set;
                    ptr_d   = o_owner;
                    if ((BARRIER_EN != 0) && (&done_set)) begin
                        row_full_d = 1'b1;
                        state_d    = BARRIER;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BARRIER: begin
                if (i_drain_done) begin
                    emptied_d  = 1'b1;
                    done_d     = '0;
                    wr_count_d = '0;
                    row_full_d = 1'b0;
                    state_d    = EMPTY;
                end
            end
            EMPTY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            ptr_q          <= OW'(NUM_CORES - 1);
            done_q         <= '0;
            timer_q        <= '0;
            o_core_grant   <= '0;
            o_owner        <= '0;
            o_uram_emptied <= 1'b0;
            o_URAM_en      <= 1'b0;
            o_URAM_wr_en   <= 1'b0;
            o_URAM_addr    <= '0;
            o_URAM_wr_data <= '0;
            o_row_full     <= 1'b0;
            o_wr_count     <= '0;
            o_timeout_err  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            done_q         <= done_d;
            timer_q        <= timer_d;
            o_core_grant   <= grant_d;
            o_owner        <= owner_d;
            o_uram_emptied <= emptied_d;
            o_URAM_en      <= uram_en_d;
            o_URAM_wr_en   <= uram_wr_en_d;
            o_URAM_addr    <= addr_d;
            o_URAM_wr_data <= data_d;
            o_row_full     <= row_full_d;
            o_wr_count     <= wr_count_d;
            o_timeout_err  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uram_row_arbiter.sv
// Bench for uram_row_arbiter: session table with a URAM-path scoreboard, plus drain,
// timeout, async-reset and no-barrier sequences.
module tb_uram_row_arbiter;
    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NC-1:0]      req, locked, en, wr;
    logic [NC*AW-1:0]   addr;
    logic [NC*DW-1:0]   wdata;
    logic               drain;

    logic [NC-1:0]      grant, nb_grant;
    logic               emptied, nb_emptied;
    logic               uen, uwr, nb_uen, nb_uwr;
    logic [AW-1:0]      uaddr, nb_uaddr;
    logic [DW-1:0]      udata, nb_udata;
    logic               row_full, nb_row_full;
    logic [1:0]         owner, nb_owner;
    logic [15:0]        wr_count, nb_wr_count;
    logic               terr, nb_terr;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int   cyc;
        logic wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } sb_t;
    sb_t exp_q [$];

    typedef struct {
        int core;
        bit lock;
        int nwr;
        bit exp_rf;
        int exp_wc;
        bit exp_terr;
    } sess_t;
    sess_t tbl [9];

    uram_row_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .GRANT_TIMEOUT(TO), .BARRIER_EN(1)) dut (
        .clk(clk), .reset(reset), .i_core_req(req), .o_core_grant(grant), .i_core_locked(locked),
        .o_uram_emptied(emptied), .i_URAM_en(en), .i_URAM_wr_en(wr), .i_URAM_addr(addr),
        .i_URAM_wr_data(wdata), .o_URAM_en(uen), .o_URAM_wr_en(uwr), .o_URAM_addr(uaddr),
        .o_URAM_wr_data(udata), .o_row_full(row_full), .i_drain_done(drain), .o_owner(owner),
        .o_wr_count(wr_count), .o_timeout_err(terr)
    );

    uram_row_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .GRANT_TIMEOUT(TO), .BARRIER_EN(0)) dut_nb (
        .clk(clk), .reset(reset), .i_core_req(req), .o_core_grant(nb_grant), .i_core_locked(locked),
        .o_uram_emptied(nb_emptied), .i_URAM_en(en), .i_URAM_wr_en(wr), .i_URAM_addr(addr),
        .i_URAM_wr_data(wdata), .o_URAM_en(nb_uen), .o_URAM_wr_en(nb_uwr), .o_URAM_addr(nb_uaddr),
        .o_URAM_wr_data(nb_udata), .o_row_full(nb_row_full), .i_drain_done(drain), .o_owner(nb_owner),
        .o_wr_count(nb_wr_count), .o_timeout_err(nb_terr)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each owner write must appear on the URAM port exactly one cycle later.
    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            if (mon_en && reset) begin
                if (uen) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL uram_unexpected: en=1 addr=0x%0h data=0x%0h with no write pending", uaddr, udata);
                    end else begin
                        e = exp_q.pop_front();
                        if (cyc != e.cyc || uwr !== e.wr || uaddr !== e.a || udata !== e.d) begin
                            n_fail++;
                            $display("FAIL uram_out: got cyc=%0d wr=%0b addr=0x%0h data=0x%0h, expected cyc=%0d wr=%0b addr=0x%0h data=0x%0h",
                                     cyc, uwr, uaddr, udata, e.cyc, e.wr, e.a, e.d);
                        end
                    end
                end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    n_chk++;
                    n_fail++;
                    e = exp_q.pop_front();
                    $display("FAIL uram_missing: got en=0, expected write addr=0x%0h at cycle %0d", e.a, e.cyc);
                end
            end
        end
    end

    task automatic wait_grant(input bit nb, output int lat);
        logic [NC-1:0] g;
        lat = 0;
        do begin
            step();
            lat++;
            g = nb ? nb_grant : grant;
        end while (g == '0 && lat < 40);
    endtask

    task automatic run_session(input sess_t s);
        int lat, hi, c, o;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        c = s.core;
        o = (c + 1) % NC;
        wait_grant(1'b0, lat);
        check("grant_latency", lat, 1);
        check("grant", grant, NC'(1) << c);
        check("owner", owner, c);
        if (s.lock) begin
            step();
            step();
            locked[c] = 1'b1;
            step();
            for (int w = 0; w < s.nwr; w++) begin
                a = AW'(c * 256 + w);
                d = $urandom;
                en = '0;
                wr = '0;
                en[c] = 1'b1;
                wr[c] = 1'b1;
                en[o] = 1'b1;
                wr[o] = 1'b1;
                addr[c*AW +: AW] = a;
                addr[o*AW +: AW] = 12'h055;
                wdata[c*DW +: DW] = d;
                wdata[o*DW +: DW] = $urandom;
                drain = (w == 0);
                if (w == s.nwr - 1) locked[c] = 1'b0;
                exp_q.push_back('{cyc + 1, 1'b1, a, d});
                step();
            end
            en = '0;
            wr = '0;
            drain = 1'b0;
            check("grant_drop", grant, 0);
            check("emptied_idle", emptied, 0);
        end else begin
            hi = 1;
            while (hi < 50) begin
                step();
                if (grant == '0) break;
                hi++;
            end
            check("timeout_cycles", hi, TO);
        end
        check("row_full", row_full, s.exp_rf);
        check("wr_count", wr_count, s.exp_wc);
        check("timeout_err", terr, s.exp_terr);
    endtask

    task automatic do_drain();
        repeat (3) begin
            step();
            check("barrier_no_grant", grant, 0);
            check("barrier_row_full", row_full, 1);
        end
        drain = 1'b1;
        step();
        drain = 1'b0;
        check("emptied_rise", emptied, 1);
        check("drain_wr_count", wr_count, 0);
        check("drain_row_full", row_full, 0);
        step();
        check("emptied_fall", emptied, 0);
    endtask

    initial begin
        int lat;
        tbl[0] = '{0, 1'b1, 16, 1'b0, 16, 1'b0};
        tbl[1] = '{1, 1'b1, 16, 1'b0, 32, 1'b0};
        tbl[2] = '{2, 1'b1, 16, 1'b0, 48, 1'b0};
        tbl[3] = '{3, 1'b1, 16, 1'b1, 64, 1'b0};
        tbl[4] = '{0, 1'b1, 4,  1'b0, 4,  1'b0};
        tbl[5] = '{1, 1'b1, 4,  1'b0, 8,  1'b0};
        tbl[6] = '{2, 1'b0, 0,  1'b0, 8,  1'b1};
        tbl[7] = '{3, 1'b1, 4,  1'b0, 12, 1'b1};
        tbl[8] = '{2, 1'b1, 4,  1'b1, 16, 1'b1};

        reset = 1'b0;
        req = '0;
        locked = '0;
        en = '0;
        wr = '0;
        addr = '0;
        wdata = '0;
        drain = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_owner", owner, 0);
        check("rst_uram", {uen, uwr, uaddr, udata}, 0);
        check("rst_status", {emptied, row_full, wr_count, terr}, 0);
        check("rst_nb_all", {nb_grant, nb_emptied, nb_uen, nb_uwr, nb_uaddr, nb_udata,
                             nb_row_full, nb_owner, nb_wr_count, nb_terr}, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        mon_en = 1'b1;
        req = 4'hF;

        for (int i = 0; i < 4; i++) run_session(tbl[i]);
        do_drain();
        for (int i = 4; i < 9; i++) run_session(tbl[i]);
        do_drain();

        // Async reset while core 3 owns the port with a write in flight.
        step();
        mon_en = 1'b0;
        check("sb_empty", exp_q.size(), 0);
        wait_grant(1'b0, lat);
        check("post_drain_owner", owner, 3);
        locked[3] = 1'b1;
        step();
        en[3] = 1'b1;
        wr[3] = 1'b1;
        addr[3*AW +: AW] = 12'h3A0;
        step();
        check("pre_rst_en", uen, 1);
        addr[3*AW +: AW] = 12'h3A1;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_grant", {grant, owner}, 0);
        check("async_rst_uram", {uen, uwr, uaddr, udata}, 0);
        check("async_rst_status", {emptied, row_full, wr_count, terr}, 0);
        @(negedge clk);
        req = '0;
        locked = '0;
        en = '0;
        wr = '0;
        reset = 1'b1;
        step();
        check("post_rst_en", uen, 0);
        req = 4'hF;
        wait_grant(1'b0, lat);
        check("post_rst_latency", lat, 1);
        check("post_rst_grant", grant, 4'b0001);

        // No-barrier instance: core 0 alone is re-granted every session.
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        locked = '0;
        @(negedge clk);
        reset = 1'b1;
        step();
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            wait_grant(1'b1, lat);
            check("nb_latency", lat, 1);
            check("nb_grant", nb_grant, 4'b0001);
            locked[0] = 1'b1;
            step();
            locked[0] = 1'b0;
            step();
            check("nb_grant_drop", nb_grant, 0);
            check("nb_row_full", nb_row_full, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
